crc_table: RTL and testbench

CRC_TABLE -- requirements
Module: crc_table

---
 rtl/crc_table_pkg.sv | 25 ++
 rtl/crc_table_entry.sv | 22 ++
 rtl/crc_table.sv | 77 +++++++
 tb/tb_crc_table.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/crc_table_pkg.sv
// Shared CRC-8 table definitions: default polynomial, table depth, entry type,
// init-engine states and a behavioural crc8_byte helper.
package crc_table_pkg;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam int         TABLE_DEPTH       = 256;

  typedef logic [7:0] entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_e;

  // Shifts a byte through the CRC register eight times, MSB first.
  function automatic entry_t crc8_byte(input entry_t data, input entry_t poly);
    entry_t c;
    c = data;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_table_entry.sv
// Combinational CRC-8 of a single byte: eight unrolled shift/xor steps.
module crc_table_entry
  import crc_table_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] stage [0:8];

  assign stage[0] = data_i;

  for (genvar s = 0; s < 8; s++) begin : g_step
    assign stage[s+1] = stage[s][7] ? ({stage[s][6:0], 1'b0} ^ POLY)
                                    : {stage[s][6:0], 1'b0};
  end

  assign crc_o = stage[8];

endmodule

// File: rtl/crc_table.sv
// Registered CRC-8 lookup table filled one entry per clock after reset.
// Optional registered read port enabled by defining CRC_TABLE_LOOKUP_PORT_EN.
module crc_table
  import crc_table_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
`ifdef CRC_TABLE_LOOKUP_PORT_EN
  input  logic [7:0] lut_index,
  output logic [7:0] lut_data,
`endif
  output logic [7:0] crcTable [0:255],
  output logic       table_valid
);

  entry_t      table_q [0:TABLE_DEPTH-1];
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  init_state_e state_q;
  logic        valid_q;
  entry_t      entry_crc;

  crc_table_entry #(
    .POLY (POLY)
  ) u_entry (
    .data_i (idx_q),
    .crc_o  (entry_crc)
  );

  // idx wraps 255 -> 0 on the final write; nothing is written once idle.
  assign idx_d = idx_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        table_q[i] <= 8'h00;
      end
      idx_q   <= 8'h00;
      state_q <= ST_INIT;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          table_q[idx_q] <= entry_crc;
          idx_q          <= idx_d;
          if (idx_q == 8'hFF) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CRC_TABLE_LOOKUP_PORT_EN
  logic [7:0] lut_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lut_q <= 8'h00;
    end else begin
      lut_q <= table_q[lut_index];
    end
  end

  assign lut_data = lut_q;
`endif

  assign crcTable    = table_q;
  assign table_valid = valid_q;

endmodule

// File: tb/tb_crc_table.sv
// Directed + randomized bench for crc_table (default POLY and POLY=8'h1D),
// checked against a polynomial long-division reference model.
module tb_crc_table;

  logic       clk;
  logic       reset;
  logic [7:0] tbl_a [0:255];
  logic [7:0] tbl_b [0:255];
  logic       valid_a;
  logic       valid_b;
  int         checks;
  int         failures;
  int         n_edges;
`ifdef CRC_TABLE_LOOKUP_PORT_EN
  logic [7:0] lut_index;
  logic [7:0] lut_data_a;
  logic [7:0] lut_data_b;
`endif

  crc_table dut_a (
    .clk         (clk),
    .reset       (reset),
`ifdef CRC_TABLE_LOOKUP_PORT_EN
    .lut_index   (lut_index),
    .lut_data    (lut_data_a),
`endif
    .crcTable    (tbl_a),
    .table_valid (valid_a)
  );

  crc_table #(
    .POLY (8'h1D)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
`ifdef CRC_TABLE_LOOKUP_PORT_EN
    .lut_index   (lut_index),
    .lut_data    (lut_data_b),
`endif
    .crcTable    (tbl_b),
    .table_valid (valid_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of data * x^8 divided by the full generator x^8 + poly (GF(2)).
  function automatic logic [7:0] ref_crc(input logic [7:0] data, input logic [7:0] poly);
    logic [15:0] r;
    logic [15:0] g;
    r = {data, 8'h00};
    g = {7'b0, 1'b1, poly};
    for (int k = 15; k >= 8; k--) begin
      if (r[k]) r = r ^ (g << (k - 8));
    end
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic run_to_valid(input string tag);
    n_edges = 0;
    while (!valid_a && n_edges < 400) begin
      step();
      n_edges++;
    end
    chk({tag, "_latency"}, n_edges, 256);
    chk({tag, "_valid_b"}, {31'b0, valid_b}, 1);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("%s_a[%0h]", tag, i), tbl_a[i], ref_crc(i[7:0], 8'h07));
      chk($sformatf("%s_b[%0h]", tag, i), tbl_b[i], ref_crc(i[7:0], 8'h1D));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("%s_a[%0h]", tag, i), tbl_a[i], 0);
    end
  endtask

  initial begin
    int abort_at;
    logic [7:0] idx;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
`ifdef CRC_TABLE_LOOKUP_PORT_EN
    lut_index = 8'h00;
`endif
    #2;

    // reset state
    do_reset(2);
    chk("rst_valid", {31'b0, valid_a}, 0);
    chk("rst_t01", tbl_a[8'h01], 0);
    chk("rst_tff", tbl_a[8'hFF], 0);

    // first build: edge 255 still invalid, edge 256 valid
    repeat (255) step();
    chk("edge255_valid", {31'b0, valid_a}, 0);
    chk("edge255_t01", tbl_a[8'h01], 8'h07);
    step();
    chk("edge256_valid", {31'b0, valid_a}, 1);
    chk("t00", tbl_a[8'h00], 8'h00);
    chk("t01", tbl_a[8'h01], 8'h07);
    chk("t02", tbl_a[8'h02], 8'h0E);
    chk("t10", tbl_a[8'h10], 8'h70);
    chk("t80", tbl_a[8'h80], 8'h89);
    chk("tff", tbl_a[8'hFF], 8'hF3);
    chk("b_t01", tbl_b[8'h01], 8'h1D);
    check_all("build1");

    // idle: table must be static
    repeat (1000 + $urandom_range(0, 50)) step();
    chk("idle_valid", {31'b0, valid_a}, 1);
    check_all("idle");
    for (int k = 0; k < 16; k++) begin
      idx = 8'($urandom_range(0, 255));
      chk($sformatf("rand_a[%0h]", idx), tbl_a[idx], ref_crc(idx, 8'h07));
    end

`ifdef CRC_TABLE_LOOKUP_PORT_EN
    lut_index = 8'h80;
    step();
    chk("lut80", lut_data_a, 8'h89);
    lut_index = 8'h01;
    step();
    chk("lut01", lut_data_a, 8'h07);
    for (int k = 0; k < 16; k++) begin
      idx = 8'($urandom_range(0, 255));
      lut_index = idx;
      step();
      chk($sformatf("lut_a[%0h]", idx), lut_data_a, ref_crc(idx, 8'h07));
      chk($sformatf("lut_b[%0h]", idx), lut_data_b, ref_crc(idx, 8'h1D));
    end
`endif

    // abort mid-init at edge 100
    do_reset(1);
    repeat (99) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort100_valid", {31'b0, valid_a}, 0);
    check_zero("abort100");
    run_to_valid("abort100");
    check_all("abort100_rebuild");

    // reset after valid
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("postvalid_valid", {31'b0, valid_a}, 0);
    chk("postvalid_t01", tbl_a[8'h01], 0);
    run_to_valid("postvalid");
    check_all("postvalid_rebuild");

    // abort at a random init edge
    abort_at = $urandom_range(1, 255);
    do_reset(1);
    repeat (abort_at - 1) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rand_valid", {31'b0, valid_a}, 0);
    check_zero("abort_rand");
    run_to_valid("abort_rand");
    check_all("abort_rand_rebuild");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
